// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared types and constants for the PS/2 keyboard receiver.
//             Holds the frame FSM state encoding and the special scan-code
//             prefixes handled by the make-code filter.
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    // Odd parity over the data byte and its parity bit.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_sync
//  Purpose  : Brings the raw PS/2 clock and data lines into the system clock
//             domain and flags falling edges of the PS/2 clock.
//  Ports    : clock    - system clock
//             reset    - synchronous active-high reset
//             ps2_clk  - raw PS/2 clock line (asynchronous)
//             ps2_data - raw PS/2 data line (asynchronous)
//             data_s   - synchronized data line
//             clk_fall - one-cycle strobe on a synchronized PS/2 clock fall
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_sync
    import ps2_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic clk_fall
);

    logic r_clk_meta;
    logic r_clk_sync;
    logic r_clk_prev;
    logic r_data_meta;
    logic r_data_sync;

    // Flops reset to 1, the idle level of an open-collector PS/2 line, so no
    // spurious edge appears when reset is released.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    assign data_s   = r_data_sync;
    assign clk_fall = r_clk_prev & ~r_clk_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_receiver
//  Purpose  : PS/2 keyboard frame receiver. Decodes 11-bit frames, checks
//             odd parity and the stop bit, abandons stalled frames, and
//             filters break/extended prefixes so only make codes reach the
//             scan_code output.
//  Ports    : clock     - system clock
//             reset     - synchronous active-high reset
//             ps2_clk   - raw PS/2 clock line
//             ps2_data  - raw PS/2 data line
//             scan_code - last accepted make code (held)
//             key_rdy   - one-cycle pulse for a new make code
//             frame_err - one-cycle pulse on parity/stop/timeout failure
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       key_rdy,
    output logic       frame_err
);

    localparam int              C_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT_CYCLES - 1);

    logic w_data_s;
    logic w_clk_fall;

    ps2_state_t        r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_par;
    logic              r_break;
    logic [C_TO_W-1:0] r_to_cnt;
    logic [7:0]        r_scan;
    logic              r_key_rdy;
    logic              r_frame_err;

    ps2_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_s   (w_data_s),
        .clk_fall (w_clk_fall)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_par       <= 1'b0;
            r_break     <= 1'b0;
            r_to_cnt    <= '0;
            r_scan      <= 8'h00;
            r_key_rdy   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_key_rdy   <= 1'b0;
            r_frame_err <= 1'b0;

            if (r_state == ST_IDLE) begin
                r_to_cnt <= '0;
                // A high sample on a falling edge is line noise, not a start bit.
                if (w_clk_fall && !w_data_s) begin
                    r_state   <= ST_DATA;
                    r_bit_cnt <= 3'd0;
                end
            end else if (w_clk_fall) begin
                r_to_cnt <= '0;
                if (r_state == ST_DATA) begin
                    r_shift   <= {w_data_s, r_shift[7:1]};   // LSB arrives first
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= ST_PARITY;
                    end
                end else if (r_state == ST_PARITY) begin
                    r_par   <= w_data_s;
                    r_state <= ST_STOP;
                end else begin
                    r_state <= ST_IDLE;
                    if (w_data_s && parity_ok(r_shift, r_par)) begin
                        if (r_shift == BREAK_CODE) begin
                            r_break <= 1'b1;
                        end else if (r_shift == EXT_CODE) begin
                            // Extended prefix carries no key identity; break state survives it.
                        end else if (r_break) begin
                            r_break <= 1'b0;                  // release code: swallow it
                        end else begin
                            r_scan    <= r_shift;
                            r_key_rdy <= 1'b1;
                        end
                    end else begin
                        r_frame_err <= 1'b1;
                        r_break     <= 1'b0;
                    end
                end
            end else if (r_to_cnt == C_TO_LAST) begin
                // Stalled mid-frame: drop the partial byte and resynchronize.
                r_state     <= ST_IDLE;
                r_to_cnt    <= '0;
                r_shift     <= 8'h00;
                r_frame_err <= 1'b1;
                r_break     <= 1'b0;
            end else begin
                r_to_cnt <= r_to_cnt + C_TO_W'(1);
            end
        end
    end

    assign scan_code = r_scan;
    assign key_rdy   = r_key_rdy;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
